// File: rtl/fp_add_subt_responder.sv
// fp_add_subt_responder
// ---------------------
// Multi-cycle IEEE-754 adder/subtractor that answers the Begin_SUM /
// ACK_ADD_SUBT handshake of the CORDIC control FSMs. Alignment and
// normalization move one bit per cycle. Denormal inputs are flushed to zero.
// Inf/NaN inputs get no special treatment.
//
// Handshake: Begin_SUM is sampled on the rising CLK edge in IDLE or DONE.
// That edge also captures ADD_SUBT, Data_X and Data_Y. ACK_ADD_SUBT is a
// level that is high only in DONE. Result and the flags hold steady while it
// is high. Begin_SUM is ignored while an operation runs. RST or RST_EX
// abandons any operation in progress.
//
// Ports:
//   CLK            system clock
//   RST_EX         asynchronous active-high reset
//   RST            synchronous clear; returns the FSM to IDLE
//   Begin_SUM      start request
//   ADD_SUBT       0 = X+Y, 1 = X-Y
//   Data_X/Data_Y  operands (W bits)
//   ACK_ADD_SUBT   result valid level
//   Result         packed result
//   overflow_flag  result saturated to signed infinity
//   underflow_flag result flushed to signed zero
module fp_add_subt_responder #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic         CLK,
    input  logic         RST_EX,
    input  logic         RST,
    input  logic         Begin_SUM,
    input  logic         ADD_SUBT,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    output logic         ACK_ADD_SUBT,
    output logic [W-1:0] Result,
    output logic         overflow_flag,
    output logic         underflow_flag
);

    // Mantissa working format: {carry, hidden, fraction[SW-1:0], G, R, S}
    localparam int MW = SW + 5;
    // Signed exponent with headroom for carry/rounding and left shifts below 0
    localparam int XW = EW + 2;
    localparam logic [EW-1:0]        K_MAX    = EW'(SW + 3);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_COMPARE, S_ALIGN, S_ADD,
        S_NORM, S_ROUND, S_PACK, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]           x_q, y_q;
    logic                   op_q;
    logic                   sign_a, sign_b, sign_r;
    logic [EW-1:0]          exp_a, exp_b;
    logic [MW-1:0]          man_a, man_b, sum;
    logic [EW-1:0]          cnt;
    logic signed [XW-1:0]   exp_r;
    logic [SW:0]            rnd_man;
    logic [W-1:0]           result_q;
    logic                   ovf_q, unf_q;

    // Magnitude compare and capped alignment distance
    logic          a_ge_b;
    logic [EW-1:0] d_mag, k_val;
    // Rounding
    logic          round_up;
    logic [SW+1:0] rnd_sum;
    // Normalization exits when carry is set, the sum is zero, or hidden bit set
    logic          norm_done;

    function automatic logic [MW-1:0] unpack_man(input logic [W-1:0] v);
        logic hid;
        hid = |v[W-2:SW];
        unpack_man = {1'b0, hid, (hid ? v[SW-1:0] : {SW{1'b0}}), 3'b000};
    endfunction

    always_comb begin
        a_ge_b   = {exp_a, man_a} >= {exp_b, man_b};
        d_mag    = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
        k_val    = (d_mag > K_MAX) ? K_MAX : d_mag;
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd_sum  = {1'b0, sum[MW-2:3]} + (SW+2)'(round_up);
        norm_done = sum[MW-1] | sum[MW-2] | (sum == '0);
    end

    // State register
    always_ff @(posedge CLK or posedge RST_EX) begin
        if (RST_EX) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; RST wins over everything, including Begin_SUM
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (Begin_SUM) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = (k_val != '0) ? S_ALIGN : S_ADD;
            S_ALIGN:   if (cnt == EW'(1)) state_nxt = S_ADD;
            S_ADD:     state_nxt = S_NORM;
            S_NORM:    if (norm_done) state_nxt = S_ROUND;
            S_ROUND:   state_nxt = S_PACK;
            S_PACK:    state_nxt = S_DONE;
            S_DONE:    if (Begin_SUM) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
        if (RST) state_nxt = S_IDLE;
    end

    // Datapath
    always_ff @(posedge CLK or posedge RST_EX) begin
        if (RST_EX) begin
            x_q <= '0; y_q <= '0; op_q <= 1'b0;
            sign_a <= 1'b0; sign_b <= 1'b0; sign_r <= 1'b0;
            exp_a <= '0; exp_b <= '0; man_a <= '0; man_b <= '0;
            sum <= '0; cnt <= '0; exp_r <= '0; rnd_man <= '0;
            result_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0;
        end else if (RST) begin
            x_q <= '0; y_q <= '0; op_q <= 1'b0;
            sign_a <= 1'b0; sign_b <= 1'b0; sign_r <= 1'b0;
            exp_a <= '0; exp_b <= '0; man_a <= '0; man_b <= '0;
            sum <= '0; cnt <= '0; exp_r <= '0; rnd_man <= '0;
            result_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Begin_SUM) begin
                        x_q  <= Data_X;
                        y_q  <= Data_Y;
                        op_q <= ADD_SUBT;
                    end
                end
                S_LOAD: begin
                    sign_a <= x_q[W-1];
                    exp_a  <= x_q[W-2:SW];
                    man_a  <= unpack_man(x_q);
                    sign_b <= y_q[W-1] ^ op_q;
                    exp_b  <= y_q[W-2:SW];
                    man_b  <= unpack_man(y_q);
                end
                S_COMPARE: begin
                    if (!a_ge_b) begin
                        sign_a <= sign_b; sign_b <= sign_a;
                        exp_a  <= exp_b;  exp_b  <= exp_a;
                        man_a  <= man_b;  man_b  <= man_a;
                    end
                    cnt <= k_val;
                end
                S_ALIGN: begin
                    // Bit 0 is sticky: it keeps any 1 that falls off the end
                    man_b <= {1'b0, man_b[MW-1:2], man_b[1] | man_b[0]};
                    cnt   <= cnt - EW'(1);
                end
                S_ADD: begin
                    // |A| >= |B| after the swap, so the difference is never negative
                    sum    <= (sign_a == sign_b) ? (man_a + man_b) : (man_a - man_b);
                    exp_r  <= $signed({2'b00, exp_a});
                    sign_r <= sign_a;
                end
                S_NORM: begin
                    if (sum[MW-1]) begin
                        sum   <= {1'b0, sum[MW-1:2], sum[1] | sum[0]};
                        exp_r <= exp_r + XW'(1);
                    end else if (!norm_done) begin
                        sum   <= {sum[MW-2:0], 1'b0};
                        exp_r <= exp_r - XW'(1);
                    end
                end
                S_ROUND: begin
                    if (rnd_sum[SW+1]) begin
                        rnd_man <= rnd_sum[SW+1:1];
                        exp_r   <= exp_r + XW'(1);
                    end else begin
                        rnd_man <= rnd_sum[SW:0];
                    end
                end
                S_PACK: begin
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                    if (!rnd_man[SW]) begin
                        // Exact zero is always +0
                        result_q <= '0;
                    end else if (exp_r >= EXP_MAX) begin
                        result_q <= {sign_r, {EW{1'b1}}, {SW{1'b0}}};
                        ovf_q    <= 1'b1;
                    end else if (exp_r <= EXP_ZERO) begin
                        result_q <= {sign_r, {(W-1){1'b0}}};
                        unf_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_r, exp_r[EW-1:0], rnd_man[SW-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACK_ADD_SUBT   = (state == S_DONE);
    assign Result         = result_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

endmodule

// File: tb/tb_fp_add_subt_responder.sv
// Bench for fp_add_subt_responder: directed cases, handshake/reset cases and
// random operands checked against an exact-arithmetic reference model.
module tb_fp_add_subt_responder;

    logic        CLK = 1'b0;
    logic        RST_EX = 1'b1;
    logic        RST = 1'b0;
    logic        Begin_SUM = 1'b0;
    logic        ADD_SUBT = 1'b0;
    logic [31:0] Data_X = '0;
    logic [31:0] Data_Y = '0;
    logic        ACK_ADD_SUBT;
    logic [31:0] Result;
    logic        overflow_flag;
    logic        underflow_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    fp_add_subt_responder #(.W(32), .EW(8), .SW(23)) dut (
        .CLK(CLK), .RST_EX(RST_EX), .RST(RST),
        .Begin_SUM(Begin_SUM), .ADD_SUBT(ADD_SUBT),
        .Data_X(Data_X), .Data_Y(Data_Y),
        .ACK_ADD_SUBT(ACK_ADD_SUBT), .Result(Result),
        .overflow_flag(overflow_flag), .underflow_flag(underflow_flag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Exact reference: the aligned sum is formed as a wide integer, then
    // rounded to nearest-even. Operands more than 60 binades apart keep B as
    // a tiny nonzero tail, which rounds exactly like the true value.
    function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                      input logic sub, output logic [31:0] res,
                                      output logic ovf, output logic unf,
                                      output int lat);
        int ex, ey, ea, eb, d, dd, p, e, sh;
        logic sx, sy, sa, sb;
        logic [127:0] mx, my, ma, mb, s, mant, rem, half;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        sx = x[31];          sy = y[31] ^ sub;
        mx = (ex == 0) ? 128'd0 : {104'd0, 1'b1, x[22:0]};
        my = (ey == 0) ? 128'd0 : {104'd0, 1'b1, y[22:0]};
        if ((ex > ey) || (ex == ey && mx >= my)) begin
            ea = ex; ma = mx; sa = sx; eb = ey; mb = my; sb = sy;
        end else begin
            ea = ey; ma = my; sa = sy; eb = ex; mb = mx; sb = sx;
        end
        d   = ea - eb;
        dd  = (d > 60) ? 60 : d;
        lat = 6 + ((d > 26) ? 26 : d);
        s   = (sa == sb) ? ((ma << dd) + mb) : ((ma << dd) - mb);
        ovf = 1'b0; unf = 1'b0;
        if (s == 128'd0) begin
            res = 32'h0000_0000;
            return;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (s[i]) p = i;
        if (p < 23 + dd) lat += (23 + dd) - p;
        e = ea - dd + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            mant = s >> sh;
            rem  = s & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
        end else begin
            mant = s << (23 - p);
        end
        if (mant == (128'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) begin
            res = {sa, 8'hFF, 23'd0}; ovf = 1'b1;
        end else if (e <= 0) begin
            res = {sa, 31'd0}; unf = 1'b1;
        end else begin
            res = {sa, 8'(e), mant[22:0]};
        end
    endfunction

    // Issue one operation and check result, flags and latency.
    // hold=1 keeps Begin_SUM high until ACK is seen.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic sub, input logic hold, input string tag);
        logic [31:0] r;
        logic        ovf, unf;
        int          lat_exp, lat;
        ref_model(x, y, sub, r, ovf, unf, lat_exp);
        exp_q.push_back(r);
        @(negedge CLK);
        Data_X = x; Data_Y = y; ADD_SUBT = sub; Begin_SUM = 1'b1;
        @(posedge CLK); #1;
        if (!hold) Begin_SUM = 1'b0;
        check({tag, "_ack_low"}, {31'd0, ACK_ADD_SUBT}, 32'd0);
        lat = 0;
        while (!ACK_ADD_SUBT && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
        end
        Begin_SUM = 1'b0;
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_result"}, Result, exp_q.pop_front());
        check({tag, "_ovf"}, {31'd0, overflow_flag}, {31'd0, ovf});
        check({tag, "_unf"}, {31'd0, underflow_flag}, {31'd0, unf});
    endtask

    task automatic expect_no_ack(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (ACK_ADD_SUBT) seen++;
        end
        check(tag, seen, 0);
    endtask

    function automatic logic [31:0] rand_fp(input int e);
        logic [31:0] v;
        v = {$urandom_range(0, 1) == 1, 8'(e), 23'($urandom)};
        return v;
    endfunction

    initial begin
        logic [31:0] x, y;
        int ex, ey;

        // Reset state
        #12;
        check("rst_ack", {31'd0, ACK_ADD_SUBT}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
        @(negedge CLK); RST_EX = 1'b0;

        // Directed cases
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, "add_carry");
        check("add_carry_value", Result, 32'h40000000);
        run_op(32'h3FC00000, 32'h3F800000, 1'b1, 1'b0, "sub_norm");
        check("sub_norm_value", Result, 32'h3F000000);
        run_op(32'h3F800000, 32'h33800000, 1'b0, 1'b0, "tie_even");
        check("tie_even_value", Result, 32'h3F800000);
        run_op(32'h3F800001, 32'h33800000, 1'b0, 1'b0, "tie_up");
        check("tie_up_value", Result, 32'h3F800002);
        run_op(32'h3F800000, 32'h30800000, 1'b0, 1'b0, "align_cap");
        check("align_cap_value", Result, 32'h3F800000);
        run_op(32'h40490FDB, 32'h40490FDB, 1'b1, 1'b0, "cancel");
        check("cancel_value", Result, 32'h00000000);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, "ovf");
        check("ovf_value", Result, 32'h7F800000);
        repeat (4) @(posedge CLK);
        #1;
        check("ovf_held", {31'd0, overflow_flag}, 32'd1);
        check("ovf_held_result", Result, 32'h7F800000);
        check("ovf_held_ack", {31'd0, ACK_ADD_SUBT}, 32'd1);
        run_op(32'h00800000, 32'h00C00000, 1'b1, 1'b0, "unf");
        run_op(32'h00000000, 32'hC0000000, 1'b0, 1'b0, "zero_a");

        // Begin_SUM held high for the whole operation
        run_op(32'h41200000, 32'hBF800000, 1'b0, 1'b1, "hold");
        check("hold_value", Result, 32'h41100000);
        repeat (3) @(posedge CLK);
        #1;
        check("hold_ack_stays", {31'd0, ACK_ADD_SUBT}, 32'd1);
        check("hold_result_stays", Result, 32'h41100000);

        // RST_EX during ALIGN
        @(negedge CLK);
        Data_X = 32'h3F800000; Data_Y = 32'h30800000; ADD_SUBT = 1'b0; Begin_SUM = 1'b1;
        @(posedge CLK); #1; Begin_SUM = 1'b0;
        repeat (8) @(posedge CLK);
        #1; RST_EX = 1'b1;
        #1;
        check("rstex_ack", {31'd0, ACK_ADD_SUBT}, 32'd0);
        check("rstex_result", Result, 32'd0);
        @(negedge CLK); @(negedge CLK); RST_EX = 1'b0;
        expect_no_ack(40, "rstex_no_ack");
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, "after_rstex");

        // Synchronous RST clears the held result; RST beats Begin_SUM
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_sync_ack", {31'd0, ACK_ADD_SUBT}, 32'd0);
        check("rst_sync_result", Result, 32'd0);
        @(negedge CLK);
        Data_X = 32'h3F800000; Data_Y = 32'h3F800000; Begin_SUM = 1'b1;
        @(negedge CLK); RST = 1'b0; Begin_SUM = 1'b0;
        expect_no_ack(30, "rst_prio_no_ack");

        // Random operands
        for (int t = 0; t < 150; t++) begin
            ex = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 254);
            case ($urandom_range(0, 3))
                0: ey = $urandom_range(0, 254);
                1: ey = ex;
                default: begin
                    ey = ex + $urandom_range(0, 60) - 30;
                    if (ey < 0) ey = 0;
                    if (ey > 254) ey = 254;
                end
            endcase
            x = rand_fp(ex);
            y = ($urandom_range(0, 9) == 0) ? x : rand_fp(ey);
            run_op(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
